// File: rtl/prbs31_pkg.sv
// prbs31_pkg
//   Shared definitions for the PRBS31 burst sequencer:
//   - command opcodes accepted on the 8-bit command stream
//   - sequencer state encoding
//   - default (all-ones) LFSR seed and polynomial tap positions (x^31+x^28+1)
//   - single-bit LFSR step helper used by the byte stepper
package prbs31_pkg;

  localparam logic [7:0] OP_SEED     = 8'h01;
  localparam logic [7:0] OP_START    = 8'h02;
  localparam logic [7:0] OP_RUN_STOP = 8'h03;

  localparam logic [30:0] PRBS31_DEFAULT_SEED = 31'h7FFF_FFFF;

  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_LEN  = 3'd2,
    ST_RUN  = 3'd3,
    ST_FREE = 3'd4
  } state_t;

  // One LFSR bit step: the feedback bit is both the output bit and the new LSB.
  function automatic logic [30:0] prbs31_bit_step(input logic [30:0] s);
    return {s[29:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs31_byte_step.sv
// prbs31_byte_step
//   Combinational eight-bit advance of the PRBS31 LFSR.
//   Ports:
//     state       in  [30:0]  current LFSR state
//     next_state  out [30:0]  LFSR state after eight bit steps
//     data        out [7:0]   generated byte, first-generated bit in bit 7
module prbs31_byte_step
  import prbs31_pkg::*;
(
  input  logic [30:0] state,
  output logic [30:0] next_state,
  output logic [7:0]  data
);

  logic [30:0] work;

  always_comb begin
    work = state;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      data[7-i] = work[TAP_HI] ^ work[TAP_LO];
      work      = prbs31_bit_step(work);
    end
    next_state = work;
  end

endmodule

// File: rtl/prbs31_burst_ctrl.sv
// prbs31_burst_ctrl
//   Command-driven sequencer around the PRBS31 byte generator. Opcodes and
//   argument bytes arrive on an 8-bit valid/ready command stream; PRBS bytes
//   leave on a valid/ready output stream. The LFSR only advances when an
//   output byte is actually accepted, and an all-zero seed is replaced by the
//   all-ones default so the generator can never lock up.
//   Ports:
//     clk        in       clock
//     rst_n      in       asynchronous reset, active-high (despite the name)
//     cmd_valid  in       command byte valid
//     cmd_data   in  [7]  command/argument byte
//     cmd_ready  out      command byte accepted when cmd_valid & cmd_ready
//     out_valid  out      PRBS byte valid
//     out_data   out [7]  PRBS byte, first-generated bit in bit 7
//     out_ready  in       downstream accepts byte when out_valid & out_ready
//     busy       out      high whenever the sequencer is not idle
//     done       out      one-cycle pulse: counted burst finished or stop took effect
//     seed_fix   out      one-cycle pulse: zero seed replaced by default
//     cmd_err    out      one-cycle pulse: unknown or illegal opcode
module prbs31_burst_ctrl
  import prbs31_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       seed_fix,
  output logic       cmd_err
);

  localparam int LEN_BYTES = (LEN_W + 7) / 8;
  localparam int LEN_SR_W  = LEN_BYTES * 8;
  localparam logic [7:0] LEN_LAST_IDX  = 8'(LEN_BYTES - 1);
  localparam logic [7:0] SEED_LAST_IDX = 8'd3;

  state_t              state;
  logic [30:0]         lfsr;
  logic [30:0]         lfsr_next;
  logic [7:0]          prbs_byte;
  logic [LEN_W-1:0]    count;
  logic                stop_pend;
  logic [7:0]          arg_idx;
  logic [23:0]         seed_sr;
  logic [LEN_SR_W-1:0] len_sr;
  logic [LEN_SR_W-1:0] len_full;
  logic [LEN_W-1:0]    len_value;
  logic [30:0]         seed_full;
  logic                cmd_fire;
  logic                xfer;
  logic                stop_cmd;
  logic                last_count;

  prbs31_byte_step u_step (
    .state      (lfsr),
    .next_state (lfsr_next),
    .data       (prbs_byte)
  );

  // Every state can take a command byte, so the command side never stalls.
  assign cmd_ready = 1'b1;
  assign out_data  = prbs_byte;
  assign busy      = (state != ST_IDLE);

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign xfer       = out_valid & out_ready;
  assign stop_cmd   = cmd_fire && (cmd_data == OP_RUN_STOP);
  assign last_count = (count == LEN_W'(1));

  // Seed and length are assembled MSB first; the incoming byte is the LSB
  // so the final argument byte can be used in the same cycle it arrives.
  // Bit 31 of the seed falls off the top here.
  assign seed_full = {seed_sr[22:0], cmd_data};

  always_comb begin
    len_full      = len_sr << 8;
    len_full[7:0] = cmd_data;
  end

  assign len_value = len_full[LEN_W-1:0];

  // Sequencer: command decoding, argument collection, burst counting and the
  // output handshake. A stop (pending, or arriving together with a transfer)
  // only ends the run on a transfer, so out_valid never falls without one.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= PRBS31_DEFAULT_SEED;
      count     <= '0;
      stop_pend <= 1'b0;
      arg_idx   <= '0;
      seed_sr   <= '0;
      len_sr    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      seed_fix  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      seed_fix <= 1'b0;
      cmd_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (cmd_data)
              OP_SEED: begin
                state   <= ST_SEED;
                arg_idx <= '0;
              end
              OP_START: begin
                state   <= ST_LEN;
                arg_idx <= '0;
                len_sr  <= '0;
              end
              OP_RUN_STOP: begin
                state     <= ST_FREE;
                out_valid <= 1'b1;
                stop_pend <= 1'b0;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end

        ST_SEED: begin
          if (cmd_fire) begin
            seed_sr <= seed_full[23:0];
            arg_idx <= arg_idx + 8'd1;
            if (arg_idx == SEED_LAST_IDX) begin
              state <= ST_IDLE;
              if (seed_full == 31'd0) begin
                lfsr     <= PRBS31_DEFAULT_SEED;
                seed_fix <= 1'b1;
              end else begin
                lfsr <= seed_full;
              end
            end
          end
        end

        ST_LEN: begin
          if (cmd_fire) begin
            len_sr  <= len_full;
            arg_idx <= arg_idx + 8'd1;
            if (arg_idx == LEN_LAST_IDX) begin
              if (len_value == '0) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                state     <= ST_RUN;
                count     <= len_value;
                out_valid <= 1'b1;
                stop_pend <= 1'b0;
              end
            end
          end
        end

        ST_RUN: begin
          if (cmd_fire && !stop_cmd) begin
            cmd_err <= 1'b1;
          end
          if (xfer) begin
            lfsr  <= lfsr_next;
            count <= count - LEN_W'(1);
            if (last_count || stop_pend || stop_cmd) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
            end
          end else if (stop_cmd) begin
            stop_pend <= 1'b1;
          end
        end

        ST_FREE: begin
          if (cmd_fire && !stop_cmd) begin
            cmd_err <= 1'b1;
          end
          if (xfer) begin
            lfsr <= lfsr_next;
            if (stop_pend || stop_cmd) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
            end
          end else if (stop_cmd) begin
            stop_pend <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// tb_prbs31_burst_ctrl
//   Self-checking bench for prbs31_burst_ctrl. Expected bytes come from an
//   independent PRBS31 model (or literal vectors) and are queued when a burst
//   is commanded; a monitor pops and compares on every output transfer.
module tb_prbs31_burst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       seed_fix;
  logic       cmd_err;

  int checkCount;
  int passCount;

  logic [7:0]  expQ[$];
  logic [30:0] modelLfsr;

  prbs31_burst_ctrl #(.LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .seed_fix  (seed_fix),
    .cmd_err   (cmd_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference PRBS31 (x^31+x^28+1): eight bit steps, first bit into bit 7.
  function automatic logic [7:0] modelByte(input logic [30:0] s, output logic [30:0] ns);
    logic [7:0] b;
    logic       fb;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      fb     = s[30] ^ s[27];
      b[7-i] = fb;
      s      = {s[29:0], fb};
    end
    ns = s;
    return b;
  endfunction

  task automatic pushModel(input int n);
    logic [30:0] ns;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(modelByte(modelLfsr, ns));
      modelLfsr = ns;
    end
  endtask

  // Literal all-ones-seed vector; also advances the model past those bytes.
  task automatic pushDefaultVector();
    logic [30:0] ns;
    logic [7:0]  vec [4];
    vec = '{8'h00, 8'h00, 8'h00, 8'h0E};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(vec[i]);
      void'(modelByte(modelLfsr, ns));
      modelLfsr = ns;
    end
  endtask

  // Present one command byte and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [7:0] b);
    logic accepted;
    int   tries;
    accepted  = 1'b0;
    tries     = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!accepted && tries < 20) begin
      @(negedge clk);
      accepted = cmd_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic loadSeed(input logic [31:0] seed);
    applyStimulus(8'h01);
    applyStimulus(seed[31:24]);
    applyStimulus(seed[23:16]);
    applyStimulus(seed[15:8]);
    applyStimulus(seed[7:0]);
    modelLfsr = (seed[30:0] == 31'd0) ? 31'h7FFF_FFFF : seed[30:0];
  endtask

  task automatic startBurst(input logic [15:0] len);
    applyStimulus(8'h02);
    applyStimulus(len[15:8]);
    applyStimulus(len[7:0]);
  endtask

  // Wait until the sequencer drops busy; done must pulse in that same cycle
  // and be gone the next.
  task automatic waitIdle(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (busy && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  // Scoreboard monitor: every accepted output byte must match the queue head.
  always @(negedge clk) begin
    if (!rst_n && out_valid && out_ready) begin
      checkOutput("sb_pending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) checkOutput("sb_byte", 32'(out_data), 32'(expQ.pop_front()));
    end
  end

  initial begin
    logic [7:0] firstByte;
    int         unstable;

    checkCount = 0;
    passCount  = 0;
    cmd_valid  = 1'b0;
    cmd_data   = 8'h00;
    out_ready  = 1'b0;
    modelLfsr  = 31'h7FFF_FFFF;
    rst_n      = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset values, observed while reset is still asserted.
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pulses", {29'd0, done, seed_fix, cmd_err}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // All-ones seed, burst of 4 with downstream always ready.
    out_ready = 1'b1;
    loadSeed(32'hFFFF_FFFF);
    pushDefaultVector();
    startBurst(16'd4);
    checkOutput("burst1_busy", 32'(busy), 32'd1);
    checkOutput("burst1_valid", 32'(out_valid), 32'd1);
    waitIdle("burst1", 50);

    // Zero seed gets replaced, giving the same sequence.
    loadSeed(32'h0000_0000);
    checkOutput("zero_seed_fix", 32'(seed_fix), 32'd1);
    pushDefaultVector();
    startBurst(16'd4);
    waitIdle("burst2", 50);

    // Bit 31 is dropped, so this seed is zero as well.
    loadSeed(32'h8000_0000);
    checkOutput("b31_seed_fix", 32'(seed_fix), 32'd1);

    // Arbitrary seed, burst of 3.
    loadSeed(32'h1234_5678);
    checkOutput("plain_seed_no_fix", 32'(seed_fix), 32'd0);
    pushModel(3);
    startBurst(16'd3);
    waitIdle("burst3", 50);

    // Zero length: done with the last length byte, no output.
    startBurst(16'd0);
    checkOutput("zlen_done", 32'(done), 32'd1);
    checkOutput("zlen_busy", 32'(busy), 32'd0);
    checkOutput("zlen_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("zlen_done_once", 32'(done), 32'd0);
    checkOutput("zlen_still_quiet", 32'(out_valid), 32'd0);

    // Backpressure: byte must hold steady while out_ready is low.
    out_ready = 1'b0;
    pushModel(4);
    startBurst(16'd4);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    firstByte = out_data;
    unstable  = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_data !== firstByte) unstable++;
    end
    checkOutput("bp_stable", 32'(unstable), 32'd0);
    out_ready = 1'b1;
    waitIdle("bp", 50);

    // Free run: nine bytes, stop while stalled, tenth byte still delivered.
    pushModel(10);
    applyStimulus(8'h03);
    repeat (9) @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(8'h03);
    checkOutput("free_stop_busy", 32'(busy), 32'd1);
    checkOutput("free_stop_valid", 32'(out_valid), 32'd1);
    checkOutput("free_stop_noerr", 32'(cmd_err), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("free_end_busy", 32'(busy), 32'd0);
    checkOutput("free_end_valid", 32'(out_valid), 32'd0);
    checkOutput("free_end_done", 32'(done), 32'd1);
    checkOutput("free_drained", 32'(expQ.size()), 32'd0);

    // Stop arriving together with the last counted byte: one done, idle.
    pushModel(1);
    startBurst(16'd1);
    out_ready = 1'b1;
    applyStimulus(8'h03);
    checkOutput("coinc_busy", 32'(busy), 32'd0);
    checkOutput("coinc_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("coinc_done_once", 32'(done), 32'd0);
    checkOutput("coinc_valid", 32'(out_valid), 32'd0);

    // Illegal opcodes: in idle, and a non-stop byte during a run.
    applyStimulus(8'h55);
    checkOutput("err_idle", 32'(cmd_err), 32'd1);
    checkOutput("err_idle_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
    pushModel(6);
    startBurst(16'd6);
    applyStimulus(8'h02);
    checkOutput("err_run", 32'(cmd_err), 32'd1);
    checkOutput("err_run_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    waitIdle("err_burst", 50);

    // Reset in the middle of a seed load discards it and restores all-ones.
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midseed_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b0;
    modelLfsr = 31'h7FFF_FFFF;
    pushDefaultVector();
    startBurst(16'd4);
    waitIdle("post_rst", 50);

    checkOutput("sb_final_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
